cnn_frame_sequencer: RTL

//  Frame-level controller for the 3-stage conv/relu/maxpool + dense inference pipeline.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/cnn_watchdog.sv | 28 ++
 rtl/cnn_frame_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN inference pipeline control blocks.
//   state_t    : frame sequencer states
//   IMG_H/W    : image geometry
//   DATA_WIDTH : pixel width, CLASS_W : dense class output width
package cnn_pkg;
  localparam int IMG_H      = 24;
  localparam int IMG_W      = 24;
  localparam int DATA_WIDTH = 8;
  localparam int CLASS_W    = 8;

  typedef enum logic [2:0] {
    IDLE, FETCH, PRES, WAIT_ACK, FLUSH, WAIT_RES, DONE
  } state_t;
endpackage

// File: rtl/cnn_watchdog.sv
// Saturating cycle watchdog shared by the row-ack and dense-result waits.
//   clk, resetn : clock, async active-low reset
//   i_clr       : restart the count at zero
//   i_en        : count this cycle
//   i_limit     : cycles allowed; o_expire fires in the last of them
//   o_expire    : combinational expiry while enabled
module cnn_watchdog #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expire
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  r_cnt <= '0;
    else if (i_clr)               r_cnt <= '0;
    else if (i_en && r_cnt != '1) r_cnt <= r_cnt + W'(1);
  end

  // Count k is held in the (k+1)-th waiting cycle; expiring at limit-1 lets
  // the registered frame_done land exactly limit cycles after entry.
  assign o_expire = i_en && (r_cnt >= i_limit - W'(1));
endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller: pops image rows from the row FIFO, presents them to
// the first line buffer paced by the conv-1 ack, appends zero flush rows, then
// waits for the dense class result.
//   clk, resetn       : clock, async active-low reset
//   start_i, abort_i  : frame start (IDLE only), synchronous abort
//   fifo_empty_i      : row FIFO empty;  fifo_ren_o : FIFO read strobe
//   row_valid_o       : line buffer valid strobe; row_zero_o : zero-row select
//   row_ack_i         : conv-1 per-row done
//   dense_valid_i/data: dense class result
//   busy_o, result_o, result_valid_o, frame_done_o, err_tmo_o : status
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int H          = IMG_H,
  parameter int FLUSH_ROWS = 1,
  parameter int ACK_TMO    = 4096,
  parameter int RES_TMO    = 65535
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               fifo_empty_i,
  output logic               fifo_ren_o,
  output logic               row_valid_o,
  output logic               row_zero_o,
  input  logic               row_ack_i,
  input  logic               dense_valid_i,
  input  logic [CLASS_W-1:0] dense_data_i,
  output logic               busy_o,
  output logic [CLASS_W-1:0] result_o,
  output logic               result_valid_o,
  output logic               frame_done_o,
  output logic               err_tmo_o
);
  localparam int RC_W   = $clog2(H + FLUSH_ROWS + 1);
  localparam int WD_MAX = (ACK_TMO > RES_TMO) ? ACK_TMO : RES_TMO;
  localparam int WD_W   = $clog2(WD_MAX + 1);
  localparam logic [RC_W-1:0] ROWS_IMG = RC_W'(H);
  localparam logic [RC_W-1:0] ROWS_ALL = RC_W'(H + FLUSH_ROWS);

  state_t             r_state, w_state_nxt;
  logic [RC_W-1:0]    r_row_cnt, w_row_cnt_nxt;
  logic               r_ren, r_row_valid, r_row_zero, r_busy;
  logic               r_frame_done, r_result_valid, r_err;
  logic [CLASS_W-1:0] r_result;
  logic               w_ren_nxt, w_valid_nxt, w_zero_nxt, w_done_nxt, w_rv_nxt;
  logic               w_tmo_set, w_err_clr, w_capture;
  logic               w_ack, w_wd_clr, w_wd_en, w_wd_expire;
  logic [WD_W-1:0]    w_wd_limit;

  // An ack coinciding with row_valid_o belongs to no presented row yet.
  assign w_ack      = (r_state == WAIT_ACK) && row_ack_i && !r_row_valid;
  assign w_wd_en    = (r_state == WAIT_ACK) || (r_state == WAIT_RES);
  assign w_wd_limit = (r_state == WAIT_RES) ? WD_W'(RES_TMO) : WD_W'(ACK_TMO);
  assign w_wd_clr   = ((w_state_nxt == WAIT_ACK) && (r_state != WAIT_ACK)) ||
                      ((w_state_nxt == WAIT_RES) && (r_state != WAIT_RES));

  cnn_watchdog #(.W(WD_W)) u_wd (
    .clk      (clk),
    .resetn   (resetn),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .i_limit  (w_wd_limit),
    .o_expire (w_wd_expire)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_row_cnt_nxt = r_row_cnt;
    w_ren_nxt     = 1'b0;
    w_valid_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_rv_nxt      = 1'b0;
    w_tmo_set     = 1'b0;
    w_err_clr     = 1'b0;
    w_capture     = 1'b0;
    unique case (r_state)
      IDLE: if (start_i) begin
        w_state_nxt   = FETCH;
        w_row_cnt_nxt = '0;
        w_err_clr     = 1'b1;
      end
      FETCH: if (!fifo_empty_i) begin
        w_ren_nxt   = 1'b1;
        w_state_nxt = PRES;
      end
      PRES, FLUSH: begin
        w_valid_nxt = 1'b1;
        w_state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        // A late ack in the expiry cycle still wins.
        if (w_ack) begin
          w_row_cnt_nxt = r_row_cnt + RC_W'(1);
          if (w_row_cnt_nxt < ROWS_IMG)      w_state_nxt = FETCH;
          else if (w_row_cnt_nxt < ROWS_ALL) w_state_nxt = FLUSH;
          else                               w_state_nxt = WAIT_RES;
        end else if (w_wd_expire) begin
          w_tmo_set   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WAIT_RES: begin
        if (dense_valid_i) begin
          w_capture   = 1'b1;
          w_rv_nxt    = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else if (w_wd_expire) begin
          w_tmo_set   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Abort overrides everything; in DONE the frame has already reported.
    if (abort_i && r_state != DONE) begin
      w_state_nxt   = IDLE;
      w_row_cnt_nxt = r_row_cnt;
      w_ren_nxt     = 1'b0;
      w_valid_nxt   = 1'b0;
      w_rv_nxt      = 1'b0;
      w_tmo_set     = 1'b0;
      w_err_clr     = 1'b0;
      w_capture     = 1'b0;
      w_done_nxt    = (r_state != IDLE);
    end
  end

  // Flush rows are those presented once the image rows are exhausted.
  assign w_zero_nxt = ((w_state_nxt == FLUSH) || (w_state_nxt == WAIT_ACK)) &&
                      (w_row_cnt_nxt >= ROWS_IMG);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_row_cnt      <= '0;
      r_ren          <= 1'b0;
      r_row_valid    <= 1'b0;
      r_row_zero     <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_result       <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_row_cnt      <= w_row_cnt_nxt;
      r_ren          <= w_ren_nxt;
      r_row_valid    <= w_valid_nxt;
      r_row_zero     <= w_zero_nxt;
      r_busy         <= (w_state_nxt != IDLE);
      r_frame_done   <= w_done_nxt;
      r_result_valid <= w_rv_nxt;
      if (w_capture) r_result <= dense_data_i;
      if (w_tmo_set)      r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
    end
  end

  assign fifo_ren_o     = r_ren;
  assign row_valid_o    = r_row_valid;
  assign row_zero_o     = r_row_zero;
  assign busy_o         = r_busy;
  assign frame_done_o   = r_frame_done;
  assign result_valid_o = r_result_valid;
  assign result_o       = r_result;
  assign err_tmo_o      = r_err;
endmodule
